// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning the HI/LO pair.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HIWrite,
  input  logic        LOWrite,
  input  logic [31:0] WData,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy,
  output logic        Done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_state_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic [1:0]  r_op;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic        r_busy, r_done;
  logic        w_start, w_commit, w_dz, w_ovf;
  logic [31:0] w_div_b;
  logic signed [31:0] w_sq, w_sr;
  logic [63:0] w_prod, w_div_res, w_res;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start     = 1'b0;
    w_commit    = 1'b0;
    if (r_state == IDLE) begin
      w_start = Start;
      if (Start) begin
        w_state_nxt = RUN;
        w_cnt_nxt   = Op[1] ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
      end
    end else begin
      w_cnt_nxt = r_cnt - 5'd1;
      w_commit  = r_cnt == 5'd1;
      if (w_commit) w_state_nxt = IDLE;
    end
  end
  // Low 64 bits of the sign-extended product are the exact signed product.
  assign w_prod = r_op[0] ? {32'h0, r_a} * {32'h0, r_b}
                          : {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_dz    = r_b == 32'h0;
  assign w_ovf   = !r_op[0] && r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF;
  // Divisor forced to 1 on the special cases so the divider never sees 0 or overflows.
  assign w_div_b = (w_dz || w_ovf) ? 32'd1 : r_b;
  assign w_sq    = $signed(r_a) / $signed(w_div_b);
  assign w_sr    = $signed(r_a) % $signed(w_div_b);
  assign w_div_res = w_dz    ? {r_a, 32'hFFFF_FFFF} :
                     w_ovf   ? {32'h0, 32'h8000_0000} :
                     r_op[0] ? {r_a % w_div_b, r_a / w_div_b} :
                               {w_sr, w_sq};
  assign w_res = r_op[1] ? w_div_res : w_prod;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= 5'd0;
      r_op    <= 2'd0;
      r_a     <= 32'h0;
      r_b     <= 32'h0;
      r_hi    <= 32'h0;
      r_lo    <= 32'h0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_state_nxt == RUN;
      r_done  <= w_commit;
      if (w_start) begin
        r_op <= Op;
        r_a  <= A;
        r_b  <= B;
      end
      if (w_commit) {r_hi, r_lo} <= w_res;
      else if (r_state == IDLE && !Start) begin
        if (HIWrite) r_hi <= WData;
        if (LOWrite) r_lo <= WData;
      end
    end
  end
  assign HI   = r_hi;
  assign LO   = r_lo;
  assign Busy = r_busy;
  assign Done = r_done;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu; expected HI/LO queued at issue, checked on Done.
module tb_mdu;
  logic        Clk, Reset, Start, HIWrite, LOWrite;
  logic [1:0]  Op;
  logic [31:0] A, B, WData, HI, LO;
  logic        Busy, Done;
  int          tests = 0, fails = 0;
  logic [63:0] sb_q[$];

  mdu dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .HIWrite(HIWrite), .LOWrite(LOWrite), .WData(WData),
    .HI(HI), .LO(LO), .Busy(Busy), .Done(Done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Done) begin
      if (sb_q.size() == 0) chk("sb_unexpected_done", 64'd1, 64'd0);
      else chk("result", {HI, LO}, sb_q.pop_front());
    end
  end

  // Called at a negedge; returns one negedge later with Start dropped.
  task automatic go(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] hi, input logic [31:0] lo, input bit push);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    if (push) sb_q.push_back({hi, lo});
    @(negedge Clk);
    Start = 1'b0;
    A     = 32'h5A5A_5A5A;
    B     = 32'h0;
  endtask

  task automatic wait_done(input int n);
    int c = 0;
    logic [63:0] hl = {HI, LO};
    while (Busy && c < 64) begin
      if ({HI, LO} !== hl) chk("hold", {HI, LO}, hl);
      c++;
      @(negedge Clk);
    end
    chk("busy_len", 64'(c), 64'(n));
    chk("done_pulse", 64'(Done), 64'd1);
  endtask

  initial begin
    int dones;
    Reset = 1'b1; Start = 1'b0; Op = 2'd0; A = 32'h0; B = 32'h0;
    HIWrite = 1'b0; LOWrite = 1'b0; WData = 32'h0;
    repeat (2) @(negedge Clk);
    chk("rst_hilo", {HI, LO}, 64'h0);
    chk("rst_busy_done", {62'h0, Busy, Done}, 64'h0);
    Reset = 1'b0;
    @(negedge Clk);

    go(2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1);
    wait_done(5);
    @(negedge Clk);
    chk("done_one_cycle", 64'(Done), 64'd0);

    go(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
    wait_done(5);
    @(negedge Clk);

    go(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    wait_done(10);
    @(negedge Clk);

    go(2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1);
    wait_done(10);
    @(negedge Clk);

    // Start and MTHI during a DIV run must be ignored.
    go(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    Start = 1'b1; Op = 2'b00; A = 32'd5; B = 32'd5;
    HIWrite = 1'b1; WData = 32'h1234_5678;
    @(negedge Clk);
    Start = 1'b0; HIWrite = 1'b0;
    chk("busy_mid_run", 64'(Busy), 64'd1);
    wait_done(9);
    @(negedge Clk);
    HIWrite = 1'b1; WData = 32'h1234_5678;
    @(negedge Clk);
    HIWrite = 1'b0;
    chk("mthi", {HI, LO}, {32'h1234_5678, 32'd14});
    HIWrite = 1'b1; LOWrite = 1'b1; WData = 32'hCAFE_F00D;
    @(negedge Clk);
    HIWrite = 1'b0; LOWrite = 1'b0;
    chk("mthi_mtlo", {HI, LO}, {32'hCAFE_F00D, 32'hCAFE_F00D});

    // Start wins over a simultaneous MTHI.
    HIWrite = 1'b1; WData = 32'hDEAD_BEEF;
    go(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b1);
    HIWrite = 1'b0;
    chk("start_over_mthi", {HI, LO}, {32'hCAFE_F00D, 32'hCAFE_F00D});
    wait_done(5);
    @(negedge Clk);

    // Reset mid-DIV aborts without a commit.
    go(2'b10, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("abort_state", {HI, LO}, 64'h0);
    chk("abort_flags", {62'h0, Busy, Done}, 64'h0);
    dones = 0;
    repeat (12) begin
      @(negedge Clk);
      if (Done) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);

    go(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
    wait_done(5);
    @(negedge Clk);

    go(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b1);
    wait_done(10);
    // Back-to-back issue in the Done cycle.
    go(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    chk("b2b_busy", 64'(Busy), 64'd1);
    wait_done(10);
    @(negedge Clk);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
